// File: rtl/fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// fifo_wptr_full
// Write-side controller of the async FIFO. Drives the write port of
// dualport_mem, keeps the binary/Gray write pointers, synchronises the
// read-domain Gray pointer into w_clk and produces registered full, sticky
// overflow and a pessimistic fill level.
//
// Optional feature macro: FIFO_AFULL_EN (adds the registered w_afull port).
//
// Ports
//   w_clk       in   write-domain clock, all state on posedge
//   w_rst       in   synchronous active-high reset
//   w_inc       in   push request
//   r_ptr_gray  in   read-domain Gray pointer (asynchronous to w_clk)
//   w_en        out  memory write enable
//   w_addr      out  memory write address
//   w_ptr_gray  out  registered Gray write pointer, to the read domain
//   w_full      out  registered full flag
//   w_overflow  out  sticky: push attempted while full
//   w_count     out  registered fill level 0..DEPTH (pessimistic)
//   w_afull     out  registered almost-full (FIFO_AFULL_EN only)
// -----------------------------------------------------------------------------
module fifo_wptr_full #(
  parameter int DEPTH        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_inc,
  input  logic [ADDR_W:0]   r_ptr_gray,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W:0]   w_ptr_gray,
  output logic              w_full,
  output logic              w_overflow,
  output logic [ADDR_W:0]   w_count
`ifdef FIFO_AFULL_EN
  ,
  output logic              w_afull
`endif
);

  // Elaboration-time legality checks on the configuration.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_wptr_full: DEPTH must be a power of 2 and >= 4");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("fifo_wptr_full: SYNC_STAGES must be 2..4");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH - 1) begin : g_bad_afull
    $error("fifo_wptr_full: AFULL_THRESH must be 1..DEPTH-1");
  end

  logic [ADDR_W:0] w_bin;
  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] rq;
  logic [ADDR_W:0] bnext;
  logic [ADDR_W:0] gnext;
  logic [ADDR_W:0] full_cmp;
  logic [ADDR_W:0] count_next;
  logic            accept;
  logic            full_next;

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Reset also blocks the memory write so nothing lands while pointers clear.
  assign accept = w_inc & ~w_full & ~w_rst;
  assign w_en   = accept;
  assign w_addr = w_bin[ADDR_W-1:0];

  assign rq = sync_q[SYNC_STAGES-1];

  always_comb begin
    bnext      = w_bin + {{ADDR_W{1'b0}}, accept};
    gnext      = bnext ^ (bnext >> 1);
    // Full in Gray space: top two bits inverted, the rest equal.
    full_cmp   = {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]};
    full_next  = (gnext == full_cmp);
    count_next = bnext - gray2bin(rq);
  end

  // Plain flop chain: nothing but Gray values cross, no logic between stages.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= r_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      w_bin      <= '0;
      w_ptr_gray <= '0;
      w_full     <= 1'b0;
      w_overflow <= 1'b0;
      w_count    <= '0;
    end else begin
      w_bin      <= bnext;
      w_ptr_gray <= gnext;
      w_full     <= full_next;
      w_count    <= count_next;
      if (w_inc && w_full) begin
        w_overflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_AFULL_EN
  localparam logic [ADDR_W:0] AFULL_LVL = AFULL_THRESH[ADDR_W:0];

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      w_afull <= 1'b0;
    end else begin
      w_afull <= (count_next >= AFULL_LVL);
    end
  end
`endif

endmodule
